interrupt_controller: RTL and testbench

//  Upstream source of the core's 2-bit interrupt input. Merges a machine timer
//  (mtime/mtimecmp) and one asynchronous external line into a single prioritised request code.

---
 rtl/irq_pkg.sv | 30 +++
 rtl/irq_sync.sv | 39 +++
 rtl/interrupt_controller.sv | 183 ++++++++++++++++++
 tb/tb_interrupt_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// ============================================================================
//  Module   : irq_pkg
//  Purpose  : Shared types and constants for the interrupt controller:
//             FSM state encoding, request codes and config register map.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package irq_pkg;

  // One-hot state encoding; any illegal pattern falls back to IDLE
  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    PENDING = 3'b010,
    SERVICE = 3'b100
  } irq_state_e;

  // Request codes presented to the core
  localparam logic [1:0] IRQ_NONE = 2'b00;
  localparam logic [1:0] IRQ_EXT  = 2'b01;
  localparam logic [1:0] IRQ_TMR  = 2'b10;

  // Config register map
  localparam logic [1:0] CFG_MTIMECMP = 2'd0;
  localparam logic [1:0] CFG_MTIME    = 2'd1;
  localparam logic [1:0] CFG_ENABLE   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/irq_sync.sv
// ============================================================================
//  Module   : irq_sync
//  Purpose  : Multi-flop synchroniser bringing an asynchronous level into the
//             clk domain. Output is the last flop of the chain.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Chain flops clear asynchronously so no stale level survives reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
//  Module   : interrupt_controller
//  Purpose  : Merges a machine timer (mtime/mtimecmp) and one asynchronous
//             external line into a prioritised 2-bit request code, holds it
//             until acknowledged and masks new requests until mret completes.
//  Build    : IRQ_CTRL_EXT_EDGE_EN defined -> external pend is edge-triggered;
//             otherwise it follows the synchronised level.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module interrupt_controller
  import irq_pkg::*;
#(
  parameter int TIMER_W     = 32,
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_irq,
  input  logic               irq_ack,
  input  logic               irq_done,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_addr,
  input  logic [TIMER_W-1:0] cfg_wdata,
  output logic [TIMER_W-1:0] cfg_rdata,
  output logic [1:0]         interrupt,
  output logic               busy
);

  localparam int                 PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]    PS_MAX  = PS_W'(PRESCALE - 1);
  localparam logic [TIMER_W-1:0] TMR_MAX = '1;

  logic [TIMER_W-1:0] mtime_q, mtime_d;
  logic [TIMER_W-1:0] mtimecmp_q, mtimecmp_d;
  logic [PS_W-1:0]    presc_q, presc_d;
  logic [1:0]         enable_q, enable_d;
  logic               pend_t_q, pend_t_d;
  logic               pend_e_q, pend_e_d;
  logic               armed_q, armed_d;
`ifdef IRQ_CTRL_EXT_EDGE_EN
  logic               ext_prev_q;
`endif
  irq_state_e         state_q;
  logic [1:0]         code_q;
  logic               busy_q;

  logic ext_sync;
  logic wr_cmp, wr_time, wr_en;
  logic tick, wrap, tmr_match;
  logic ack_ok, ack_ext, ack_tmr;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_irq),
    .q   (ext_sync)
  );

  assign wr_cmp    = cfg_wr && (cfg_addr == CFG_MTIMECMP);
  assign wr_time   = cfg_wr && (cfg_addr == CFG_MTIME);
  assign wr_en     = cfg_wr && (cfg_addr == CFG_ENABLE);
  assign tick      = (presc_q == PS_MAX);
  assign wrap      = tick && (mtime_q == TMR_MAX);
  assign tmr_match = (mtime_q >= mtimecmp_q);
  // code_q doubles as the latched request while PENDING
  assign ack_ok    = (state_q == PENDING) && irq_ack;
  assign ack_ext   = ack_ok && (code_q == IRQ_EXT);
  assign ack_tmr   = ack_ok && (code_q == IRQ_TMR);

  // Timer advance and config register writes; a write overrides the increment
  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    mtime_d    = tick ? mtime_q + 1'b1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    enable_d   = enable_q;
    if (wr_time) mtime_d    = cfg_wdata;
    if (wr_cmp)  mtimecmp_d = cfg_wdata;
    if (wr_en)   enable_d   = cfg_wdata[1:0];
  end

  // Pend flags. The timer match is a level, so after its request is taken it
  // stays disarmed until mtimecmp is rewritten or mtime wraps around.
  always_comb begin
    armed_d = armed_q;
    if (ack_tmr)          armed_d = 1'b0;
    if (wrap || wr_cmp)   armed_d = 1'b1;

    pend_t_d = pend_t_q | (tmr_match & armed_q & enable_q[0]);
    if (ack_tmr || wr_cmp || wr_time || !enable_q[0]) pend_t_d = 1'b0;

`ifdef IRQ_CTRL_EXT_EDGE_EN
    pend_e_d = pend_e_q;
    if (ack_ext)                 pend_e_d = 1'b0;
    if (ext_sync && !ext_prev_q) pend_e_d = 1'b1;
    if (!enable_q[1])            pend_e_d = 1'b0;
`else
    pend_e_d = ext_sync & enable_q[1] & ~ack_ext;
`endif
  end

  // Timer, config and pend state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      enable_q   <= 2'b00;
      pend_t_q   <= 1'b0;
      pend_e_q   <= 1'b0;
      armed_q    <= 1'b1;
`ifdef IRQ_CTRL_EXT_EDGE_EN
      ext_prev_q <= 1'b0;
`endif
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      enable_q   <= enable_d;
      pend_t_q   <= pend_t_d;
      pend_e_q   <= pend_e_d;
      armed_q    <= armed_d;
`ifdef IRQ_CTRL_EXT_EDGE_EN
      ext_prev_q <= ext_sync;
`endif
    end
  end

  // Request FSM with registered code and busy outputs; external beats timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= IRQ_NONE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_e_q || pend_t_q) begin
            state_q <= PENDING;
            code_q  <= pend_e_q ? IRQ_EXT : IRQ_TMR;
          end
        end
        PENDING: begin
          if (irq_ack) begin
            state_q <= SERVICE;
            code_q  <= IRQ_NONE;
            busy_q  <= 1'b1;
          end
        end
        SERVICE: begin
          if (irq_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          code_q  <= IRQ_NONE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational config read-back; reserved address reads zero
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_MTIMECMP: cfg_rdata = mtimecmp_q;
      CFG_MTIME:    cfg_rdata = mtime_q;
      CFG_ENABLE:   cfg_rdata = {{(TIMER_W-2){1'b0}}, enable_q};
      default:      cfg_rdata = '0;
    endcase
  end

  assign interrupt = code_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
//  Module   : tb_interrupt_controller
//  Purpose  : Self-checking bench for interrupt_controller (default params).
//             Expected timing is derived from a bench-side mtime value and
//             the documented latencies.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst, ext_irq, irq_ack, irq_done, cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic [1:0]  interrupt;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cur;     // bench's own notion of mtime (PRESCALE = 1)

  interrupt_controller dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .irq_ack(irq_ack),
    .irq_done(irq_done), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .interrupt(interrupt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock; mtime advances by one each cycle
  task automatic tick();
    @(posedge clk); #1;
    cur = cur + 1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr = 1'b0; cfg_addr = 2'd1;
    if (a == 2'd1) cur = d;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1; tick(); irq_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    rst = 1'b1; ext_irq = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    cfg_wr = 1'b0; cfg_addr = 2'd1; cfg_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (interrupt !== 2'b00) begin n_err++; $display("FAIL reset_code: got %b want 00", interrupt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a); #1;
      n_cmp++; if (cfg_rdata !== exp_rd[a]) begin n_err++; $display("FAIL reset_reg%0d: got %h want %h", a, cfg_rdata, exp_rd[a]); end
    end
    cfg_addr = 2'd1;
    @(posedge clk); #1;
    rst = 1'b0; cur = 32'd0;
    pulse_ack();
    n_cmp++; if (busy !== 1'b0 || interrupt !== 2'b00) begin n_err++; $display("FAIL idle_ack_ignored: got busy=%b code=%b want 0/00", busy, interrupt); end
    n_cmp++; if (cfg_rdata !== cur) begin n_err++; $display("FAIL mtime_count: got %0d want %0d", cfg_rdata, cur); end
  endtask

  task automatic test_timer();
    logic [31:0] m, c;
    int w;
    for (int it = 0; it < 3; it++) begin
      m = $urandom_range(0, 100000);
      c = m + $urandom_range(5, 25);
      wr(2'd2, 32'd0); wr(2'd1, m); wr(2'd0, c); wr(2'd2, 32'd1);
      for (int k = 0; k < 40 && cur != c + 2; k++) begin
        n_cmp++; if (interrupt !== 2'b00) begin n_err++; $display("FAIL timer_early: mtime=%0d got %b want 00", cur, interrupt); end
        tick();
      end
      n_cmp++; if (interrupt !== 2'b10) begin n_err++; $display("FAIL timer_fire: mtime=%0d got %b want 10", cur, interrupt); end
      n_cmp++; if (cfg_rdata !== cur) begin n_err++; $display("FAIL timer_mtime: got %0d want %0d", cfg_rdata, cur); end
      pulse_ack();
      n_cmp++; if (interrupt !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL timer_ack: got code=%b busy=%b want 00/1", interrupt, busy); end
      w = $urandom_range(1, 5);
      repeat (w) tick();
      n_cmp++; if (interrupt !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL timer_service: got code=%b busy=%b want 00/1", interrupt, busy); end
      pulse_done();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL timer_done: got busy=%b want 0", busy); end
      for (int k = 0; k < 6; k++) begin
        tick();
        n_cmp++; if (interrupt !== 2'b00) begin n_err++; $display("FAIL timer_disarmed: got %b want 00", interrupt); end
      end
    end
    wr(2'd2, 32'd0);
  endtask

  // Timer and external pend flags become set on the same clock edge
  task automatic test_priority();
    logic [31:0] m, c;
    m = $urandom_range(100, 50000);
    c = m + 8;
    wr(2'd2, 32'd0); wr(2'd1, m); wr(2'd0, c); wr(2'd2, 32'd3);
    for (int k = 0; k < 20 && cur != c - 2; k++) tick();
    ext_irq = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (interrupt !== ((k == 4) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL prio_ext_first: step %0d got %b want %b", k, interrupt, (k == 4) ? 2'b01 : 2'b00); end
    end
    repeat (2) tick();
    n_cmp++; if (interrupt !== 2'b01) begin n_err++; $display("FAIL prio_hold: got %b want 01", interrupt); end
    ext_irq = 1'b0;
    pulse_ack();
    n_cmp++; if (interrupt !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL prio_ack: got code=%b busy=%b want 00/1", interrupt, busy); end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (interrupt !== 2'b00) begin n_err++; $display("FAIL prio_masked: got %b want 00", interrupt); end
    end
    pulse_done();
    n_cmp++; if (interrupt !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL prio_gap: got code=%b busy=%b want 00/0", interrupt, busy); end
    tick();
    n_cmp++; if (interrupt !== 2'b10) begin n_err++; $display("FAIL prio_timer_next: got %b want 10", interrupt); end
    pulse_ack(); pulse_done();
    wr(2'd2, 32'd0);
  endtask

  task automatic test_service_ext();
    logic [1:0] exp;
    wr(2'd2, 32'd2);
    ext_irq = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (interrupt !== ((k == 4) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL ext_latency: step %0d got %b want %b", k, interrupt, (k == 4) ? 2'b01 : 2'b00); end
    end
    // ack and done together in PENDING: only ack acts
    irq_ack = 1'b1; irq_done = 1'b1; ext_irq = 1'b0;
    tick();
    irq_ack = 1'b0; irq_done = 1'b0;
    n_cmp++; if (busy !== 1'b1 || interrupt !== 2'b00) begin n_err++; $display("FAIL ack_done_pending: got busy=%b code=%b want 1/00", busy, interrupt); end
    repeat (4) tick();
    ext_irq = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (interrupt !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL svc_hold: got code=%b busy=%b want 00/1", interrupt, busy); end
    end
    // ack and done together in SERVICE: only done acts
    irq_ack = 1'b1; irq_done = 1'b1;
    tick();
    irq_ack = 1'b0; irq_done = 1'b0;
    n_cmp++; if (busy !== 1'b0 || interrupt !== 2'b00) begin n_err++; $display("FAIL svc_exit: got busy=%b code=%b want 0/00", busy, interrupt); end
    tick();
    n_cmp++; if (interrupt !== 2'b01) begin n_err++; $display("FAIL svc_reissue: got %b want 01", interrupt); end
    // line held high across the whole service
    pulse_ack();
    repeat (4) tick();
    pulse_done();
    n_cmp++; if (busy !== 1'b0 || interrupt !== 2'b00) begin n_err++; $display("FAIL held_done: got busy=%b code=%b want 0/00", busy, interrupt); end
`ifdef IRQ_CTRL_EXT_EDGE_EN
    exp = 2'b00;
`else
    exp = 2'b01;
`endif
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (interrupt !== exp) begin n_err++; $display("FAIL held_line: got %b want %b", interrupt, exp); end
    end
    ext_irq = 1'b0;
    pulse_ack();
    repeat (4) tick();
    pulse_done();
    tick();
    n_cmp++; if (interrupt !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL ext_cleanup: got code=%b busy=%b want 00/0", interrupt, busy); end
    wr(2'd2, 32'd0);
  endtask

  task automatic test_wrap();
    logic [31:0] c, m;
    c = $urandom_range(2, 8);
    wr(2'd2, 32'd0); wr(2'd0, c); wr(2'd1, 32'd0); wr(2'd2, 32'd1);
    for (int k = 0; k < 20 && cur != c + 2; k++) tick();
    n_cmp++; if (interrupt !== 2'b10) begin n_err++; $display("FAIL wrap_first: got %b want 10", interrupt); end
    pulse_ack(); pulse_done();
    m = 32'hFFFF_FFFF - $urandom_range(1, 5);
    wr(2'd1, m);
    for (int k = 0; k < 40 && cur != c + 2; k++) begin
      n_cmp++; if (interrupt !== 2'b00 || cfg_rdata !== cur) begin n_err++; $display("FAIL wrap_quiet: got code=%b mtime=%h want 00/%h", interrupt, cfg_rdata, cur); end
      tick();
    end
    n_cmp++; if (interrupt !== 2'b10 || cfg_rdata !== cur) begin n_err++; $display("FAIL wrap_fire: got code=%b mtime=%h want 10/%h", interrupt, cfg_rdata, cur); end
    pulse_ack(); pulse_done();
    wr(2'd2, 32'd0);
  endtask

  task automatic test_cmp_race();
    logic [31:0] cold, cnew;
    cold = $urandom_range(50, 5000);
    cnew = cold + $urandom_range(10, 30);
    wr(2'd2, 32'd0); wr(2'd0, cold); wr(2'd1, cold - 10); wr(2'd2, 32'd1);
    for (int k = 0; k < 20 && cur != cold; k++) begin
      n_cmp++; if (interrupt !== 2'b00) begin n_err++; $display("FAIL race_pre: got %b want 00", interrupt); end
      tick();
    end
    wr(2'd0, cnew);
    cfg_addr = 2'd0; #1;
    n_cmp++; if (cfg_rdata !== cnew) begin n_err++; $display("FAIL race_rdata: got %0d want %0d", cfg_rdata, cnew); end
    cfg_addr = 2'd1;
    for (int k = 0; k < 40 && cur != cnew + 2; k++) begin
      n_cmp++; if (interrupt !== 2'b00) begin n_err++; $display("FAIL race_no_req: mtime=%0d got %b want 00", cur, interrupt); end
      tick();
    end
    n_cmp++; if (interrupt !== 2'b10) begin n_err++; $display("FAIL race_fire: got %b want 10", interrupt); end
    pulse_ack(); pulse_done();
    wr(2'd2, 32'd0);
  endtask

  task automatic test_async_reset();
    logic [31:0] c;
    c = $urandom_range(3, 9);
    wr(2'd2, 32'd0); wr(2'd0, c); wr(2'd1, 32'd0); wr(2'd2, 32'd1);
    for (int k = 0; k < 20 && cur != c + 2; k++) tick();
    n_cmp++; if (interrupt !== 2'b10) begin n_err++; $display("FAIL rst_pre: got %b want 10", interrupt); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (interrupt !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL rst_async: got code=%b busy=%b want 00/0", interrupt, busy); end
    n_cmp++; if (cfg_rdata !== 32'd0) begin n_err++; $display("FAIL rst_mtime: got %h want 0", cfg_rdata); end
    @(posedge clk); #1;
    rst = 1'b0; cur = 32'd0;
    cfg_addr = 2'd2; #1;
    n_cmp++; if (cfg_rdata !== 32'd0) begin n_err++; $display("FAIL rst_enable: got %h want 0", cfg_rdata); end
    cfg_addr = 2'd0; #1;
    n_cmp++; if (cfg_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_mtimecmp: got %h want ffffffff", cfg_rdata); end
    cfg_addr = 2'd1;
    pulse_ack();
    n_cmp++; if (busy !== 1'b0 || interrupt !== 2'b00) begin n_err++; $display("FAIL rst_ack_ignored: got busy=%b code=%b want 0/00", busy, interrupt); end
    n_cmp++; if (cfg_rdata !== cur) begin n_err++; $display("FAIL rst_mtime_run: got %0d want %0d", cfg_rdata, cur); end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_priority();
    test_service_ext();
    test_wrap();
    test_cmp_race();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
